// File: rtl/reg_exe_mem_skid.sv
// reg_exe_mem_skid: EXE/MEM pipeline register with one skid entry, flush and forwarding tap
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready + *_in     : EXE-side handshake and payload
//   out_valid/out_ready + *_out  : MEM-side handshake and registered payload
//   flush                        : kills every held instruction
//   fwd_en/fwd_addr/fwd_data     : forwarding tap from the main entry
//   occupancy                    : held entries, 0..2
module reg_exe_mem_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              memwrite_in,
  input  logic              regwrite_in,
  input  logic              wb_sel_in,
  input  logic              zero_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [ADDR_W-1:0] wr_addr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              memwrite_out,
  output logic              regwrite_out,
  output logic              wb_sel_out,
  output logic              zero_out,
  output logic [DATA_W-1:0] alu_out_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  input  logic              flush,
  output logic              fwd_en,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;
  typedef struct packed {
    logic              memwrite;
    logic              regwrite;
    logic              wb_sel;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [ADDR_W-1:0] addr;
  } entry_t;
  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_pl;
  logic   in_fire, out_fire;
  assign in_pl = {memwrite_in, regwrite_in, wb_sel_in, zero_in, alu_out_in, store_data_in, wr_addr_in};
  // handshake flags decode the state flops only, so out_ready never reaches in_ready
  assign in_ready  = state_q != SKID;
  assign out_valid = state_q != EMPTY;
  assign occupancy = state_q == SKID ? 2'd2 : state_q == FULL ? 2'd1 : 2'd0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign memwrite_out   = main_q.memwrite;
  assign regwrite_out   = main_q.regwrite;
  assign wb_sel_out     = main_q.wb_sel;
  assign zero_out       = main_q.zero;
  assign alu_out_out    = main_q.alu;
  assign store_data_out = main_q.store;
  assign wr_addr_out    = main_q.addr;
  assign fwd_en   = out_valid & main_q.regwrite & (main_q.addr != '0);
  assign fwd_addr = main_q.addr;
  assign fwd_data = main_q.alu;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_d  = in_pl;
          state_d = FULL;
        end
        FULL: begin
          if (in_fire && out_fire) main_d = in_pl;
          else if (in_fire) begin
            skid_d  = in_pl;
            state_d = SKID;
          end else if (out_fire) state_d = EMPTY;
        end
        SKID: if (out_fire) begin
          main_d  = skid_q;
          state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end else state_d = EMPTY;
    // control bits must read 0 whenever nothing is valid; data fields keep their last value
    if (state_d == EMPTY) begin
      main_d.memwrite = 1'b0;
      main_d.regwrite = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: tb/tb_reg_exe_mem_skid.sv
// tb_reg_exe_mem_skid: randomized and directed bench against a queue reference model
module tb_reg_exe_mem_skid;
  typedef struct packed {
    logic        mw, rw, wb, z;
    logic [31:0] alu, st;
    logic [4:0]  wa;
  } pl_t;
  logic        clk = 1'b0, rst, in_valid, out_ready, flush;
  pl_t         din;
  logic        in_ready, out_valid, memwrite_out, regwrite_out, wb_sel_out, zero_out, fwd_en;
  logic [31:0] alu_out_out, store_data_out, fwd_data;
  logic [4:0]  wr_addr_out, fwd_addr;
  logic [1:0]  occupancy;
  pl_t         q[$];
  pl_t         shown;
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  reg_exe_mem_skid #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .memwrite_in(din.mw), .regwrite_in(din.rw), .wb_sel_in(din.wb), .zero_in(din.z),
    .alu_out_in(din.alu), .store_data_in(din.st), .wr_addr_in(din.wa),
    .out_valid(out_valid), .out_ready(out_ready),
    .memwrite_out(memwrite_out), .regwrite_out(regwrite_out), .wb_sel_out(wb_sel_out),
    .zero_out(zero_out), .alu_out_out(alu_out_out), .store_data_out(store_data_out),
    .wr_addr_out(wr_addr_out), .flush(flush), .fwd_en(fwd_en), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .occupancy(occupancy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic pl_t rnd_pl();
    pl_t p;
    p.mw  = 1'($urandom);
    p.rw  = 1'($urandom);
    p.wb  = 1'($urandom);
    p.z   = 1'($urandom);
    p.alu = $urandom;
    p.st  = $urandom;
    p.wa  = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
    return p;
  endfunction
  // queue of held instructions; shown mirrors what the output register currently displays
  task automatic model_step();
    bit fi, fo;
    if (!rst) begin
      q.delete();
      shown = '0;
    end else if (flush) q.delete();
    else begin
      fi = in_valid && q.size() < 2;
      fo = q.size() > 0 && out_ready;
      if (fo) void'(q.pop_front());
      if (fi) q.push_back(din);
    end
    if (q.size() > 0) shown = q[0];
  endtask
  task automatic check_all();
    pl_t e;
    bit  v;
    v = q.size() > 0;
    e = v ? q[0] : shown;
    if (!v) begin
      e.mw = 1'b0;
      e.rw = 1'b0;
    end
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, q.size() < 2);
    chk("occupancy", occupancy, q.size());
    chk("memwrite_out", memwrite_out, e.mw);
    chk("regwrite_out", regwrite_out, e.rw);
    chk("wb_sel_out", wb_sel_out, e.wb);
    chk("zero_out", zero_out, e.z);
    chk("alu_out_out", alu_out_out, e.alu);
    chk("store_data_out", store_data_out, e.st);
    chk("wr_addr_out", wr_addr_out, e.wa);
    chk("fwd_en", fwd_en, v && e.rw && e.wa != 0);
    chk("fwd_addr", fwd_addr, e.wa);
    chk("fwd_data", fwd_data, e.alu);
  endtask
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    rst = 1'b0;
    flush = 1'($urandom);
    in_valid = 1'($urandom);
    out_ready = 1'($urandom);
    din = rnd_pl();
    repeat (2) begin
      cycle();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu", alu_out_out, 0);
      chk("rst_occ", occupancy, 0);
      flush = 1'($urandom);
      in_valid = 1'($urandom);
      din = rnd_pl();
    end
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    cycle();
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_occ", occupancy, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      din = rnd_pl();
      din.alu = 32'(i);
      in_valid = 1'b1;
      cycle();
      chk("stream_valid", out_valid, 1);
      chk("stream_alu", alu_out_out, i);
      chk("stream_occ_le1", occupancy <= 1, 1);
    end
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = rnd_pl();
    din.alu = 32'hAAAA0001;
    cycle();
    din = rnd_pl();
    din.alu = 32'hBBBB0002;
    cycle();
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_alu_a", alu_out_out, 32'hAAAA0001);
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("bp_hold_a", alu_out_out, 32'hAAAA0001);
    out_ready = 1'b1;
    cycle();
    chk("bp_alu_b", alu_out_out, 32'hBBBB0002);
    chk("bp_occ1", occupancy, 1);
    cycle();
    chk("bp_drained", occupancy, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    din = rnd_pl();
    din.mw = 1'b1;
    din.rw = 1'b1;
    din.alu = 32'hAAAA0001;
    cycle();
    din.alu = 32'hBBBB0002;
    cycle();
    chk("fl_occ2", occupancy, 2);
    flush = 1'b1;
    din.alu = 32'hCCCC0003;
    cycle();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_regwrite", regwrite_out, 0);
    chk("fl_memwrite", memwrite_out, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_data_hold", alu_out_out, 32'hAAAA0001);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("fl_no_emit", out_valid, 0);
    end
    in_valid = 1'b1;
    din = rnd_pl();
    din.rw = 1'b1;
    din.wa = 5'd7;
    din.alu = 32'h12345678;
    cycle();
    chk("fwd_hit_en", fwd_en, 1);
    chk("fwd_hit_addr", fwd_addr, 7);
    chk("fwd_hit_data", fwd_data, 32'h12345678);
    din.wa = 5'd0;
    cycle();
    chk("fwd_r0_en", fwd_en, 0);
    in_valid = 1'b0;
    cycle();
    repeat (3000) begin
      rst = ($urandom % 64) != 0;
      flush = ($urandom % 16) == 0;
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      din = rnd_pl();
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_exe_mem_skid.md
REG_EXE_MEM_SKID -- requirements
Module: reg_exe_mem_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the ALU result and store-data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the destination register address width.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-005 in_valid  in  1  EXE stage presents a valid instruction.
REQ-006 in_ready  out  1  block accepts input this cycle; in_fire = in_valid & in_ready.
REQ-007 memwrite_in, regwrite_in, wb_sel_in, zero_in  in  1 each  control payload.
REQ-008 alu_out_in, store_data_in  in  DATA_W each  data payload.
REQ-009 wr_addr_in  in  ADDR_W  destination register address.
REQ-010 out_valid  out  1  MEM stage payload valid.
REQ-011 out_ready  in  1  MEM stage accepts; out_fire = out_valid & out_ready.
REQ-012 memwrite_out, regwrite_out, wb_sel_out, zero_out, alu_out_out, store_data_out, wr_addr_out  out  same widths  registered payload.
REQ-013 flush  in  1  discard all held instructions (branch/exception kill).
REQ-014 fwd_en  out  1  forwarding hit: out_valid & regwrite_out & (wr_addr_out != 0).
REQ-015 fwd_addr, fwd_data  out  ADDR_W, DATA_W  equal wr_addr_out and alu_out_out.
REQ-016 occupancy  out  2  number of held entries, 0..2.

Function
REQ-017 The block SHALL hold a main (output) entry and one skid entry; all outputs SHALL be registered, with no combinational path from out_ready to in_ready.
REQ-018 States SHALL be EMPTY (0 entries), FULL (main only), SKID (main+skid); occupancy = 0/1/2 respectively.
REQ-019 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID.
REQ-020 EMPTY: in_fire -> load main, go FULL; else stay.
REQ-021 FULL: in_fire & out_fire -> load main, stay FULL; in_fire & !out_fire -> load skid, go SKID; !in_fire & out_fire -> EMPTY; neither -> hold.
REQ-022 SKID: out_fire -> main <= skid, go FULL; else hold both.
REQ-023 Latency from in_fire in EMPTY to out_valid=1 SHALL be exactly 1 cycle; throughput SHALL be one instruction per cycle when out_ready=1.
REQ-024 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush or reset.
REQ-025 Payload outputs SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 flush=1 SHALL force next state EMPTY, clear memwrite_out and regwrite_out, and discard any same-cycle in_fire; flush has priority over every other event.
REQ-027 The data payload (alu_out_out, store_data_out, wr_addr_out, wb_sel_out, zero_out) SHALL hold its value on flush.
REQ-028 When out_valid=0, memwrite_out and regwrite_out SHALL be 0.
REQ-029 fwd_en SHALL be 0 whenever out_valid=0 and whenever wr_addr_out = 0.

Reset
REQ-030 While rst=0 at posedge clk, the state SHALL go to EMPTY, and all payload outputs, out_valid, fwd_en and occupancy SHALL become 0.
REQ-031 in_ready SHALL be 1 in the first cycle after rst returns to 1.
REQ-032 Reset mid-operation SHALL discard both entries, and reset SHALL take priority over flush and handshakes.

Verification
REQ-033 Reset: rst=0 for 2 cycles with random inputs -> all outputs 0; in_ready=1 and occupancy=0 after release.
REQ-034 Streaming: out_ready=1, 10 back-to-back inputs with alu_out_in=1..10 -> out_valid from cycle 1, alu_out_out=1..10 in consecutive cycles, occupancy never exceeds 1.
REQ-035 Backpressure: out_ready=0, inputs A=0xAAAA0001 then B=0xBBBB0002 -> occupancy=2, in_ready=0, output holds A; raise out_ready -> A then B, then occupancy=0.
REQ-036 Flush in SKID with concurrent in_valid=1 -> next cycle: out_valid=0, regwrite_out=0, memwrite_out=0, occupancy=0, and the input is never emitted.
REQ-037 Forwarding: regwrite_in=1, wr_addr_in=7, alu_out_in=0x12345678 -> next cycle fwd_en=1, fwd_addr=7, fwd_data=0x12345678; the same with wr_addr_in=0 -> fwd_en=0.
